// File: rtl/branch_prediction_unit_if.sv
// Signal bundle between the RV32I pipeline (IF/EX stages) and the branch predictor.
// NOBRANCH normally comes from the shared parameter header; the fallback keeps this block standalone.
`ifndef NOBRANCH
`define NOBRANCH 3'b000
`endif

interface branch_prediction_unit_if;
    // IF-stage lookup
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;

    // EX-stage resolve and training
    logic [2:0]  BranchTypeE;
    logic        BranchE;
    logic [31:0] PCE;
    logic [31:0] BrTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        StallE;
    logic        MispredictE;
    logic [31:0] CorrectPCE;

    // Statistics
    logic [31:0] BranchCnt;
    logic [31:0] MispredCnt;

    modport master (
        output PCF,
        output BranchTypeE, BranchE, PCE, BrTargetE, PredTakenE, PredTargetE, StallE,
        input  PredTakenF, PredTargetF, MispredictE, CorrectPCE, BranchCnt, MispredCnt
    );

    modport slave (
        input  PCF,
        input  BranchTypeE, BranchE, PCE, BrTargetE, PredTakenE, PredTargetE, StallE,
        output PredTakenF, PredTargetF, MispredictE, CorrectPCE, BranchCnt, MispredCnt
    );
endinterface

// File: rtl/branch_prediction_unit.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational IF lookup,
// EX-stage resolve/redirect, and training on the rising edge.
module branch_prediction_unit #(
    parameter int IDX_BITS = 4
) (
    input logic                     clk,
    input logic                     rst,
    branch_prediction_unit_if.slave bp
);
    localparam int          TAG_BITS = 30 - IDX_BITS;
    localparam int unsigned ENTRIES  = 1 << IDX_BITS;

    logic                valid  [ENTRIES];
    logic [TAG_BITS-1:0] tag    [ENTRIES];
    logic [31:0]         target [ENTRIES];
    logic [1:0]          ctr    [ENTRIES];

    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    logic [IDX_BITS-1:0] idx_f;
    logic [IDX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0] tag_f;
    logic [TAG_BITS-1:0] tag_e;
    logic                hit_f;
    logic                hit_e;
    logic                pred_taken;
    logic                active;
    logic                mispredict;
    logic [1:0]          ctr_next;

    assign idx_f = bp.PCF[IDX_BITS+1:2];
    assign tag_f = bp.PCF[31:IDX_BITS+2];
    assign idx_e = bp.PCE[IDX_BITS+1:2];
    assign tag_e = bp.PCE[31:IDX_BITS+2];

    // IF lookup reads the registered table only, so a same-cycle EX write is not forwarded
    always_comb begin
        hit_f      = valid[idx_f] && (tag[idx_f] == tag_f);
        pred_taken = hit_f && ctr[idx_f][1];
    end

    assign bp.PredTakenF  = pred_taken;
    assign bp.PredTargetF = pred_taken ? target[idx_f] : bp.PCF + 32'd4;

    always_comb begin
        active     = (bp.BranchTypeE != `NOBRANCH) && !bp.StallE;
        mispredict = active &&
                     ((bp.PredTakenE != bp.BranchE) ||
                      (bp.PredTakenE && bp.BranchE && (bp.PredTargetE != bp.BrTargetE)));
    end

    assign bp.MispredictE = mispredict;
    assign bp.CorrectPCE  = bp.BranchE ? bp.BrTargetE : bp.PCE + 32'd4;

    always_comb begin
        hit_e    = valid[idx_e] && (tag[idx_e] == tag_e);
        ctr_next = ctr[idx_e];
        if (bp.BranchE) begin
            if (ctr[idx_e] != 2'b11) begin
                ctr_next = ctr[idx_e] + 2'd1;
            end
        end else if (ctr[idx_e] != 2'b00) begin
            ctr_next = ctr[idx_e] - 2'd1;
        end
    end

    // A miss only allocates on a taken branch; a not-taken miss leaves the aliasing entry intact
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= 2'b01;
            end
        end else if (active) begin
            if (hit_e) begin
                ctr[idx_e] <= ctr_next;
                if (bp.BranchE) begin
                    target[idx_e] <= bp.BrTargetE;
                end
            end else if (bp.BranchE) begin
                valid[idx_e]  <= 1'b1;
                tag[idx_e]    <= tag_e;
                target[idx_e] <= bp.BrTargetE;
                ctr[idx_e]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (active) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

    assign bp.BranchCnt  = branch_cnt;
    assign bp.MispredCnt = mispred_cnt;
endmodule
